// File: rtl/reg_cmd_pkg.sv
// -----------------------------------------------------------------------------
// reg_cmd_pkg
// Shared definitions for the UART-to-register-file command controller:
//   - state_t  : controller FSM state encoding
//   - CMD_WR   : command byte that starts a register write (address, data)
//   - CMD_RD   : command byte that starts a register read (address)
//   - ERR_BYTE : byte returned to the host when a read gets no answer
// -----------------------------------------------------------------------------
package reg_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ADDR  = 3'd1,
      WR_DATA  = 3'd2,
      RD_ADDR  = 3'd3,
      RD_ISSUE = 3'd4,
      RD_WAIT  = 3'd5,
      TX_SEND  = 3'd6
   } state_t;

   localparam logic [7:0] CMD_WR   = 8'hAA;
   localparam logic [7:0] CMD_RD   = 8'hBB;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// reg_cmd_ctrl
// Decodes a byte stream from a UART receiver into register-file accesses.
//   Write: CMD_WR, addr, data  -> addr_en pulse, then WrEn pulse
//   Read : CMD_RD, addr        -> addr_en pulse, RdEn pulse, wait for
//                                 RdData_Valid, return the byte on tx_*
//
// Parameters
//   WIDTH      : data byte / register width
//   ADDR_W     : register-file address width (must be <= WIDTH)
//   RD_TIMEOUT : cycles to wait in RD_WAIT before answering ERR_BYTE
//                (only used when REQ_CMD_TIMEOUT_EN is defined)
//
// Ports
//   CLK, RST      : clock, synchronous active-high reset
//   rx_data/valid : byte strobe from the UART receiver
//   WrEn, RdEn    : register-file write / read strobes (one cycle)
//   addr_en       : address-latch strobe, Address valid with it
//   WrData        : write data, valid with WrEn
//   RrData        : read data, valid with RdData_Valid
//   tx_data/valid : byte offered to the UART transmitter, held until tx_ready
//   rx_drop       : pulse when an rx byte arrives while a read is in flight
//
// Configuration
//   `define REQ_CMD_TIMEOUT_EN adds a read-timeout counter in RD_WAIT.
//   Without it RD_WAIT waits forever and no counter is built.
//
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module reg_cmd_ctrl
   import reg_cmd_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_W     = 4,
   parameter int RD_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  rx_data,
   input  logic              rx_valid,
   output logic              WrEn,
   output logic              RdEn,
   output logic              addr_en,
   output logic [ADDR_W-1:0] Address,
   output logic [WIDTH-1:0]  WrData,
   input  logic [WIDTH-1:0]  RrData,
   input  logic              RdData_Valid,
   output logic [WIDTH-1:0]  tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              rx_drop
);

   // Elaboration-time sanity on the parameter set.
   if (ADDR_W > WIDTH) begin : g_bad_addr_w
      $error("reg_cmd_ctrl: ADDR_W must not exceed WIDTH");
   end
   if (RD_TIMEOUT < 1) begin : g_bad_timeout
      $error("reg_cmd_ctrl: RD_TIMEOUT must be at least 1");
   end

   state_t              state_q;
   logic                wr_en_q;
   logic                rd_en_q;
   logic                addr_en_q;
   logic [ADDR_W-1:0]   address_q;
   logic [WIDTH-1:0]    wr_data_q;
   logic [WIDTH-1:0]    tx_data_q;
   logic                tx_valid_q;
   logic                rx_drop_q;

`ifdef REQ_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   logic [CNT_W-1:0]    tmo_cnt_q;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         addr_en_q  <= 1'b0;
         address_q  <= '0;
         wr_data_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rx_drop_q  <= 1'b0;
`ifdef REQ_CMD_TIMEOUT_EN
         tmo_cnt_q  <= '0;
`endif
      end else begin
         // Strobes are single-cycle: cleared every edge unless re-set below.
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         addr_en_q <= 1'b0;
         rx_drop_q <= 1'b0;

         unique case (state_q)
            IDLE: begin
               // Unknown bytes are swallowed without flagging rx_drop.
               if (rx_valid) begin
                  if (rx_data == WIDTH'(CMD_WR))      state_q <= WR_ADDR;
                  else if (rx_data == WIDTH'(CMD_RD)) state_q <= RD_ADDR;
               end
            end

            WR_ADDR: begin
               if (rx_valid) begin
                  // Upper byte bits are dropped, so addresses wrap.
                  address_q <= rx_data[ADDR_W-1:0];
                  addr_en_q <= 1'b1;
                  state_q   <= WR_DATA;
               end
            end

            WR_DATA: begin
               if (rx_valid) begin
                  wr_data_q <= rx_data;
                  wr_en_q   <= 1'b1;
                  state_q   <= IDLE;
               end
            end

            RD_ADDR: begin
               if (rx_valid) begin
                  address_q <= rx_data[ADDR_W-1:0];
                  addr_en_q <= 1'b1;
                  state_q   <= RD_ISSUE;
               end
            end

            RD_ISSUE: begin
               rd_en_q   <= 1'b1;
               rx_drop_q <= rx_valid;
               state_q   <= RD_WAIT;
`ifdef REQ_CMD_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end

            RD_WAIT: begin
               rx_drop_q <= rx_valid;
               if (RdData_Valid) begin
                  tx_data_q  <= RrData;
                  tx_valid_q <= 1'b1;
                  state_q    <= TX_SEND;
               end
`ifdef REQ_CMD_TIMEOUT_EN
               // Last waiting cycle: answer with the error byte instead.
               else if (tmo_cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                  tx_data_q  <= WIDTH'(ERR_BYTE);
                  tx_valid_q <= 1'b1;
                  state_q    <= TX_SEND;
               end else begin
                  tmo_cnt_q  <= tmo_cnt_q + CNT_W'(1);
               end
`endif
            end

            TX_SEND: begin
               rx_drop_q <= rx_valid;
               // tx_data is left untouched so it stays stable while offered.
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign WrEn     = wr_en_q;
   assign RdEn     = rd_en_q;
   assign addr_en  = addr_en_q;
   assign Address  = address_q;
   assign WrData   = wr_data_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign rx_drop  = rx_drop_q;

endmodule
